// File: rtl/mdu_unit_pkg.sv
// Shared MD-unit encodings, latency defaults and class-decode helpers.
// MDU_MADD_EN enables decoding of madd/maddu/msub/msubu (MDOp 7-10).
package mdu_unit_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MADD  = 4'd7,
        MD_MADDU = 4'd8,
        MD_MSUB  = 4'd9,
        MD_MSUBU = 4'd10
    } md_op_e;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    typedef enum logic [2:0] {CLS_NONE, CLS_MUL, CLS_DIV, CLS_MTHI, CLS_MTLO} md_class_e;
    typedef enum logic [1:0] {CM_SET, CM_ADD, CM_SUB, CM_SKIP} md_commit_e;
    typedef enum logic {IDLE, RUN} md_state_e;

    function automatic md_class_e md_class(input logic [3:0] op);
        case (op)
            MD_MULT, MD_MULTU: return CLS_MUL;
            MD_DIV, MD_DIVU:   return CLS_DIV;
            MD_MTHI:           return CLS_MTHI;
            MD_MTLO:           return CLS_MTLO;
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: return CLS_MUL;
`endif
            default:           return CLS_NONE;
        endcase
    endfunction

    function automatic logic md_is_signed(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD) || (op == MD_MSUB);
    endfunction

    function automatic md_commit_e md_accum(input logic [3:0] op);
        case (op)
            MD_MADD, MD_MADDU: return CM_ADD;
            MD_MSUB, MD_MSUBU: return CM_SUB;
            default:           return CM_SET;
        endcase
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit product and quotient/remainder generation.
module mdu_arith
    import mdu_unit_pkg::*;
(
    input  logic [3:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [63:0] prod,
    output logic [31:0] quot,
    output logic [31:0] rem
);

    logic        sgn;
    logic        a_neg;
    logic        b_neg;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    always_comb begin
        sgn   = md_is_signed(MDOp);
        ext_a = {{32{sgn & A[31]}}, A};
        ext_b = {{32{sgn & B[31]}}, B};
        prod  = ext_a * ext_b;

        // Divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 without overflow.
        a_neg = sgn & A[31];
        b_neg = sgn & B[31];
        mag_a = a_neg ? -A : A;
        mag_b = b_neg ? -B : B;
        if (mag_b == '0) begin
            mag_b = 32'd1;
        end
        q_mag = mag_a / mag_b;
        r_mag = mag_a % mag_b;
        quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem   = a_neg ? -r_mag : r_mag;
    end

endmodule

// File: rtl/mdu_unit.sv
// Iterative multiply/divide unit owning HI/LO; Busy-counted latency, exception-cancel aware.
// MDU_MADD_EN (see mdu_unit_pkg) adds multiply-accumulate/subtract ops.
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Req,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    logic [3:0]  cnt, cnt_n;
    logic [31:0] p_hi, p_hi_n;
    logic [31:0] p_lo, p_lo_n;
    logic [31:0] hi_n, lo_n;
    logic [63:0] acc;
    logic [63:0] prod;
    logic [31:0] quot, rem;
    logic        accept;
    md_commit_e  mode, mode_n;
    md_state_e   state;

    mdu_arith u_arith (
        .MDOp (MDOp),
        .A    (A),
        .B    (B),
        .prod (prod),
        .quot (quot),
        .rem  (rem)
    );

    assign state  = (cnt != '0) ? RUN : IDLE;
    assign Busy   = (state == RUN);
    assign accept = Start && !Req && (state == IDLE);
    assign acc    = {HI, LO};

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt  <= '0;
            p_hi <= '0;
            p_lo <= '0;
            mode <= CM_SET;
            HI   <= '0;
            LO   <= '0;
        end else begin
            cnt  <= cnt_n;
            p_hi <= p_hi_n;
            p_lo <= p_lo_n;
            mode <= mode_n;
            HI   <= hi_n;
            LO   <= lo_n;
        end
    end

    always_comb begin
        cnt_n  = cnt;
        p_hi_n = p_hi;
        p_lo_n = p_lo;
        mode_n = mode;
        hi_n   = HI;
        lo_n   = LO;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (md_class(MDOp))
                        CLS_MUL: begin
                            cnt_n            = 4'(MULT_CYCLES);
                            {p_hi_n, p_lo_n} = prod;
                            mode_n           = md_accum(MDOp);
                        end
                        CLS_DIV: begin
                            cnt_n  = 4'(DIV_CYCLES);
                            p_hi_n = rem;
                            p_lo_n = quot;
                            mode_n = (B == '0) ? CM_SKIP : CM_SET;
                        end
                        CLS_MTHI: hi_n = A;
                        CLS_MTLO: lo_n = A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_n = cnt - 4'd1;
                // Accumulating ops read HI/LO as they stand at the commit edge.
                if (cnt == 4'd1) begin
                    case (mode)
                        CM_SET:  {hi_n, lo_n} = {p_hi, p_lo};
                        CM_ADD:  {hi_n, lo_n} = acc + {p_hi, p_lo};
                        CM_SUB:  {hi_n, lo_n} = acc - {p_hi, p_lo};
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/mdu_unit.md
# mdu_unit

Iterative multiply/divide unit in the E stage. Owns the HI/LO registers and exports the `Start`/`Busy` pair that the hazard controller consumes to stall multiply/divide instructions in D. It also accepts the exception-cancel request from CP0 so that a cancelled instruction never updates HI/LO.

## Interface
- `MULT_CYCLES`, default 5: number of Busy cycles for multiply-class ops.
- `DIV_CYCLES`, default 10: number of Busy cycles for divide-class ops.
- `clk` input 1: clock, rising edge.
- `reset` input 1: synchronous, active-low reset.
- `Start` input 1: the E-stage instruction is an MD op this cycle. Single-cycle pulse.
- `MDOp` input 4: operation select.
  - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo.
  - 7 madd, 8 maddu, 9 msub, 10 msubu (valid only with the macro).
- `A` input 32: rs operand, already forwarded.
- `B` input 32: rt operand, already forwarded.
- `Req` input 1: exception/interrupt accepted this cycle. Suppresses all starts and writes in this cycle.
- `Busy` output 1: registered; an operation is in flight.
- `HI` output 32: architectural HI register.
- `LO` output 32: architectural LO register.

## Operation
- States: IDLE and RUN. A 4-bit down-counter `cnt` drives the state; `Busy = (cnt != 0)`.
- Accept condition: `Start && !Req && !Busy`.
  - Class mult or madd: load `cnt = MULT_CYCLES`, latch the 64-bit result into pending registers `pHI`/`pLO`.
  - Class div: load `cnt = DIV_CYCLES`, latch quotient to `pLO` and remainder to `pHI`.
- mthi/mtlo: if `Start && !Req && !Busy`, write `A` to HI/LO at that edge. Busy is not asserted.
- Arithmetic:
  - mult: signed 32x32 to 64.
  - multu: unsigned 32x32 to 64.
  - div: quotient truncates toward zero; remainder takes the sign of the dividend.
  - divu: unsigned.
  - Signed 0x80000000 / -1 gives LO = 0x80000000, HI = 0.
- Divide by zero (B == 0): counter runs normally, commit is skipped, HI/LO are unchanged.
- RUN: `cnt` decrements each cycle. On the edge where `cnt == 1`, `{HI,LO} <= {pHI,pLO}` and `cnt` becomes 0.
- Illegal inputs:
  - `Start` while Busy is ignored; the hazard controller guarantees this does not happen.
  - `MDOp` 0 or an out-of-range value with `Start` is a no-op.
- `Req` does not abort an operation already in RUN. That operation belongs to an older, committed instruction and completes normally.
- Reset: `cnt = 0`, `Busy = 0`, `HI = 0`, `LO = 0`, `pHI = 0`, `pLO = 0`. Reset during RUN discards the pending result.

## Timing
- Start accepted in cycle t:
  - Busy is high in cycles t+1 .. t+N.
  - HI/LO are updated at the end of cycle t+N and hold the new values from t+N+1, with Busy low.
- mthi/mtlo in cycle t: new value visible in cycle t+1.
- Busy is registered only. The hazard controller must stall D-stage MD instructions (mult/div/mfhi/mflo/mthi/mtlo) on `Start | Busy`.
- Back-to-back: a new Start is accepted in cycle t+N+1, the first cycle Busy is low.
- HI/LO outputs are combinationally stable for the whole cycle; there is no bypass of pending results.

## Configuration
- `MDU_MADD_EN`
  - Defined: MDOp 7–10 are decoded as multiply-class ops with latency `MULT_CYCLES`.
    - madd/maddu commit `{HI,LO} + product`.
    - msub/msubu commit `{HI,LO} - product`.
    - The accumulation uses the HI/LO value at the commit edge (64-bit, wrap-around).
  - Undefined: MDOp 7–10 are no-ops.

## Structure
- Shared package/defines header:
  - MDOp encodings.
  - `MULT_CYCLES`/`DIV_CYCLES` defaults.
  - `MD_NONE` and class-decode helper constants, also used by the decoder and the hazard controller.
- Optional sub-module `mdu_arith`: purely combinational 64-bit product and quotient/remainder generation from MDOp, A and B. `mdu_unit` keeps the counter, pending registers and HI/LO.

## Test plan
- Reset, then mult with A = 0xFFFFFFFF (−1), B = 3 in cycle t → Busy high for t+1..t+5; from t+6, HI = 0xFFFFFFFF, LO = 0xFFFFFFFD.
- divu with A = 100, B = 7 → Busy for 10 cycles, then LO = 14, HI = 2. div with A = −7, B = 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- div by zero with HI = 0x11, LO = 0x22 preset via mthi/mtlo → Busy for 10 cycles, HI/LO remain 0x11/0x22.
- Start(mult) together with `Req = 1` → Busy stays 0 and HI/LO unchanged. `Req` asserted in cycle t+2 of an accepted mult → result still commits at t+5.
- reset asserted at t+3 of a div → Busy = 0, HI = LO = 0 next cycle, and no later commit.
- With `MDU_MADD_EN`: HI = 0, LO = 5, then madd A = 2, B = 3 → LO = 11 after 5 cycles. Without the macro, the same stimulus leaves LO = 5 and Busy = 0.
